// File: rtl/uart_turbo_receive.sv
// -----------------------------------------------------------------------------
// uart_turbo_receive
//
// Receive side of the two-byte "turbo" UART link. A self-contained 8N1 bit
// receiver samples rx_wire_in, and a word assembler pairs successive bytes
// into 16-bit words, high byte first.
//
// Parameters:
//   INPUT_CLOCK_FREQ  clk_in frequency in Hz
//   BAUD_RATE         line rate in baud (INPUT_CLOCK_FREQ/BAUD_RATE >= 4)
//   TIMEOUT_BITS      inter-byte timeout, in bit periods
//
// Ports:
//   clk_in      system clock
//   rst_in      asynchronous, active-high reset
//   rx_wire_in  serial line, asynchronous to clk_in, idle high
//   data_out    last completed word {first byte, second byte}
//   valid_out   one-cycle pulse: data_out just updated
//   error_out   one-cycle pulse: partial word discarded
//   busy_out    high while a word is in progress
// -----------------------------------------------------------------------------
module uart_turbo_receive #(
  parameter int INPUT_CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE        = 115_200,
  parameter int TIMEOUT_BITS     = 20
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rx_wire_in,
  output logic [15:0] data_out,
  output logic        valid_out,
  output logic        error_out,
  output logic        busy_out
);

  localparam int BIT_PERIOD     = INPUT_CLOCK_FREQ / BAUD_RATE;
  localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * BIT_PERIOD;
  localparam int CNT_W          = $clog2(BIT_PERIOD);
  localparam int TMO_W          = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BIT_PERIOD / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // Bit-level receiver states
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // Word assembler states
  localparam logic [0:0] W_HI = 1'b0;
  localparam logic [0:0] W_LO = 1'b1;

  // ---------------------------------------------------------------------------
  // Input synchronizer plus one-cycle delay for falling-edge detection.
  // Reset to the idle (high) level so reset release never looks like a start.
  // ---------------------------------------------------------------------------
  logic sync1_q, rx_s_q, rx_p_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values; blocking here would collapse the chain.
      sync1_q <= rx_wire_in;
      rx_s_q  <= sync1_q;
      rx_p_q  <= rx_s_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit FSM
  // ---------------------------------------------------------------------------
  logic [1:0]       bit_q, bit_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bidx_q, bidx_d;
  logic [7:0]       shift_q, shift_d;
  logic             byte_done, framing_err;

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    bit_d       = bit_q;
    cnt_d       = cnt_q;
    bidx_d      = bidx_q;
    shift_d     = shift_q;
    byte_done   = 1'b0;
    framing_err = 1'b0;

    case (bit_q)
      S_IDLE: begin
        // Only a genuine high-to-low transition starts a byte, so a line
        // held low after a framing error stays ignored.
        if (rx_p_q && !rx_s_q) begin
          bit_d = S_START;
          cnt_d = '0;
        end
      end

      S_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d  = '0;
          bidx_d = '0;
          // Line back high mid start bit: treat as a glitch, no error.
          bit_d  = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};  // LSB arrives first
          if (bidx_q == 3'd7) begin
            bit_d = S_STOP;
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          bit_d = S_IDLE;
          if (rx_s_q) begin
            byte_done = 1'b1;
          end else begin
            framing_err = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: bit_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word FSM: pairs bytes, handles framing errors and inter-byte timeout.
  // byte_done / framing_err only occur in S_STOP while the timeout only
  // advances in S_IDLE, so valid and error can never fire together.
  // ---------------------------------------------------------------------------
  logic [0:0]       word_q, word_d;
  logic [7:0]       hi_q, hi_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [15:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic             error_q, error_d;
  logic             busy_q, busy_d;

  always_comb begin
    word_d  = word_q;
    hi_d    = hi_q;
    tmo_d   = tmo_q;
    data_d  = data_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    case (word_q)
      W_HI: begin
        if (byte_done) begin
          hi_d   = shift_q;
          tmo_d  = '0;
          word_d = W_LO;
        end else if (framing_err) begin
          error_d = 1'b1;
          hi_d    = '0;
        end
      end

      default: begin  // W_LO
        if (byte_done) begin
          data_d  = {hi_q, shift_q};
          valid_d = 1'b1;
          hi_d    = '0;
          word_d  = W_HI;
        end else if (framing_err) begin
          error_d = 1'b1;
          hi_d    = '0;
          word_d  = W_HI;
        end else if (bit_q == S_IDLE) begin
          // Timeout counts only idle-line cycles; it holds while a byte
          // is being received.
          if (tmo_q == TMO_LAST) begin
            error_d = 1'b1;
            hi_d    = '0;
            word_d  = W_HI;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
    endcase

    // Busy covers the first byte from its START entry (a rejected glitch
    // drops it again) through to the cycle the word completes or aborts.
    busy_d = (word_d == W_LO) || (bit_d != S_IDLE);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      bit_q   <= S_IDLE;
      cnt_q   <= '0;
      bidx_q  <= '0;
      shift_q <= '0;
      word_q  <= W_HI;
      hi_q    <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      bidx_q  <= bidx_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      hi_q    <= hi_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign error_out = error_q;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_uart_turbo_receive.sv
// -----------------------------------------------------------------------------
// tb_uart_turbo_receive
//
// Directed bench for uart_turbo_receive at 100 MHz / 1 Mbaud (100 cycles per
// bit). The stimulus process serializes bytes and pushes the expected pulse
// (valid word or error with the data_out value that must be held) into a
// queue; an independent monitor pops and compares on every output pulse.
// -----------------------------------------------------------------------------
module tb_uart_turbo_receive;

  localparam int BP = 100;  // cycles per bit

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] data_out;
  logic        valid_out, error_out, busy_out;

  uart_turbo_receive #(
    .INPUT_CLOCK_FREQ(100_000_000),
    .BAUD_RATE       (1_000_000),
    .TIMEOUT_BITS    (20)
  ) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .rx_wire_in(rx),
    .data_out  (data_out),
    .valid_out (valid_out),
    .error_out (error_out),
    .busy_out  (busy_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit          is_err;
    logic [15:0] data;   // data_out value required at the pulse
    bit          timed;
    int          at;     // expected pulse cycle when timed
  } exp_t;

  exp_t exp_q[$];
  int   last_start;

  function automatic exp_t mk(input bit is_err, input logic [15:0] d,
                              input bit timed, input int at);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    e.timed  = timed;
    e.at     = at;
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: every output pulse must match the head of the queue.
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst_in && (valid_out || error_out)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {30'd0, valid_out, error_out}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {30'd0, valid_out, error_out},
              e.is_err ? 32'd1 : 32'd2);
        check(e.is_err ? "held_data" : "word_data", {16'd0, data_out},
              {16'd0, e.data});
        check("busy_at_pulse", {31'd0, busy_out}, 32'd0);
        if (e.timed) begin
          int d;
          d = cyc - e.at;
          check("timeout_cycle", (d >= -2 && d <= 2) ? e.at : cyc, e.at);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called on a falling clock edge)
  // ---------------------------------------------------------------------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    last_start = cyc;
    repeat (BP) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BP) @(negedge clk);
    end
    rx = stop_bit;
    repeat (BP) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [15:0] w);
    exp_q.push_back(mk(1'b0, w, 1'b0, 0));
    send_byte(w[15:8], 1'b1);
    send_byte(w[7:0], 1'b1);
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_data", {16'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, valid_out}, 32'd0);
    check("rst_error", {31'd0, error_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    rst_in = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy", {31'd0, busy_out}, 32'd0);

    // 1. Single word, busy held between bytes
    exp_q.push_back(mk(1'b0, 16'hA53C, 1'b0, 0));
    send_byte(8'hA5, 1'b1);
    check("busy_between_bytes", {31'd0, busy_out}, 32'd1);
    send_byte(8'h3C, 1'b1);
    repeat (50) @(negedge clk);

    // 2. Back-to-back words, zero idle
    send_word(16'h1234);
    send_word(16'hFFFF);
    send_word(16'h0000);
    repeat (50) @(negedge clk);

    // 3. Framing error on the second byte; data_out must hold 0x0000
    exp_q.push_back(mk(1'b1, 16'h0000, 1'b0, 0));
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b0);
    repeat (200) @(negedge clk);
    check("busy_after_ferr", {31'd0, busy_out}, 32'd0);
    send_word(16'hBEEF);
    repeat (50) @(negedge clk);

    // 4. Timeout: error 2000 cycles after the first byte's valid point
    //    (start driven at N -> stop sample N+952 -> valid point N+953)
    send_byte(8'h77, 1'b1);
    exp_q.push_back(mk(1'b1, 16'hBEEF, 1'b1, last_start + 953 + 2000));
    repeat (2500 - 50) @(negedge clk);
    check("busy_after_timeout", {31'd0, busy_out}, 32'd0);
    send_word(16'h0102);
    repeat (50) @(negedge clk);

    // 5. Glitch: 30 low cycles while idle
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_during_glitch", {31'd0, busy_out}, 32'd1);
    repeat (20) @(negedge clk);
    rx = 1'b1;
    repeat (BP) @(negedge clk);
    check("busy_after_glitch", {31'd0, busy_out}, 32'd0);
    send_word(16'h5AA5);
    repeat (50) @(negedge clk);

    // 6. Asynchronous reset half-way through the second byte
    send_byte(8'h9A, 1'b1);
    rx = 1'b0;
    repeat (BP) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      repeat (BP) @(negedge clk);
    end
    #2 rst_in = 1'b1;
    #1;
    check("midrst_data", {16'd0, data_out}, 32'd0);
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check("midrst_error", {31'd0, error_out}, 32'd0);
    check("midrst_busy", {31'd0, busy_out}, 32'd0);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_in = 1'b0;
    repeat (300) @(negedge clk);
    check("busy_after_reset", {31'd0, busy_out}, 32'd0);
    send_word(16'hC3E1);

    // Drain: every expected pulse must have been seen
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    repeat (200) @(negedge clk);
    check("pending_expectations", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
